// File: rtl/axi_light_pkg.sv
// rtl/axi_light_pkg.sv - shared AXI-Lite response codes, channel states and byte-merge helper
package axi_light_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_RESP} rd_state_t;

  // Widest supported data bus; narrower callers zero-pad into these widths.
  localparam int MERGE_DW = 64;
  localparam int MERGE_SW = MERGE_DW / 8;

  // Replace each byte of old_word whose strobe bit is set with the matching byte of new_word.
  function automatic logic [MERGE_DW-1:0] strb_merge(
    input logic [MERGE_DW-1:0] old_word,
    input logic [MERGE_DW-1:0] new_word,
    input logic [MERGE_SW-1:0] strb
  );
    logic [MERGE_DW-1:0] res;
    res = old_word;
    for (int b = 0; b < MERGE_SW; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_light_reg_slave_if.sv
// rtl/axi_light_reg_slave_if.sv - AXI-Lite channel bundle with master and slave views
interface if_axi_light
  import axi_light_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
);
  localparam int SW = DW / 8;

  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;

  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wvalid;
  logic          wready;

  resp_t         bresp;
  logic          bvalid;
  logic          bready;

  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;

  logic [DW-1:0] rdata;
  resp_t         rresp;
  logic          rvalid;
  logic          rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi_light_reg_slave_addr_decode.sv
// rtl/axi_light_reg_slave_addr_decode.sv - byte address to register window hit and index
module axi_light_addr_decode
  import axi_light_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_WSTRB_WIDTH = 4,
  parameter int NUM_REGS        = 8,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  localparam int IDX_W = $clog2(NUM_REGS)
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  output logic                      in_range,
  output logic [IDX_W-1:0]          idx
);
  localparam int ADDR_LSB = $clog2(AXI_WSTRB_WIDTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] WINDOW = AXI_ADDR_WIDTH'(NUM_REGS * AXI_WSTRB_WIDTH);

  logic [AXI_ADDR_WIDTH-1:0] offset;

  // Addresses below the base wrap to a huge offset, so one unsigned compare covers both ends;
  // the base is window-aligned, so offset bits give the same index as the raw address bits.
  always_comb begin
    offset   = addr - BASE_ADDR;
    in_range = (offset < WINDOW);
    idx      = offset[ADDR_LSB +: IDX_W];
  end

endmodule

// File: rtl/axi_light_reg_slave.sv
// rtl/axi_light_reg_slave.sv - AXI-Lite register bank responder with write-notify pulse
module axi_light_reg_slave
  import axi_light_pkg::*;
#(
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_WSTRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int NUM_REGS        = 8,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [AXI_DATA_WIDTH-1:0] RESET_VAL = '0,
  localparam int IDX_W = $clog2(NUM_REGS)
) (
  input  logic                               clk,
  input  logic                               reset,
  if_axi_light.slave                         s_axi,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] regs_o,
  output logic                               wr_pulse_o,
  output logic [IDX_W-1:0]                   wr_idx_o
);
  localparam int DW = AXI_DATA_WIDTH;
  localparam int AW = AXI_ADDR_WIDTH;
  localparam int SW = AXI_WSTRB_WIDTH;

  logic [DW-1:0] regs [NUM_REGS];

  wr_state_t     wr_state_q, wr_state_d;
  logic          awready_q, awready_d, wready_q, wready_d;
  logic          bvalid_q, bvalid_d;
  resp_t         bresp_q, bresp_d;
  logic          aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic          wr_pulse_d;
  logic [IDX_W-1:0] wr_idx_d;

  logic          aw_hs, w_hs, commit;
  logic [AW-1:0] wa_sel;
  logic [DW-1:0] wd_sel;
  logic [SW-1:0] ws_sel;
  logic          w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic [MERGE_DW-1:0] old_pad, new_pad, merged_pad;
  logic [MERGE_SW-1:0] strb_pad;
  logic [DW-1:0] merged;

  rd_state_t     rd_state_q, rd_state_d;
  logic          arready_q, arready_d, rvalid_q, rvalid_d;
  resp_t         rresp_q, rresp_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ar_hs, r_in_range;
  logic [IDX_W-1:0] r_idx;

  logic unused_prot, unused_merge;
  assign unused_prot  = ^{s_axi.awprot, s_axi.arprot};
  assign unused_merge = ^merged_pad;

  axi_light_addr_decode #(
    .AXI_ADDR_WIDTH(AW), .AXI_WSTRB_WIDTH(SW), .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR)
  ) u_aw_decode (.addr(wa_sel), .in_range(w_in_range), .idx(w_idx));

  axi_light_addr_decode #(
    .AXI_ADDR_WIDTH(AW), .AXI_WSTRB_WIDTH(SW), .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR)
  ) u_ar_decode (.addr(s_axi.araddr), .in_range(r_in_range), .idx(r_idx));

  // Pick held or live AW/W beats so a write commits in the cycle its second half arrives.
  always_comb begin
    aw_hs    = s_axi.awvalid & awready_q;
    w_hs     = s_axi.wvalid & wready_q;
    commit   = (wr_state_q == W_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
    wa_sel   = aw_held_q ? awaddr_q : s_axi.awaddr;
    wd_sel   = w_held_q ? wdata_q : s_axi.wdata;
    ws_sel   = w_held_q ? wstrb_q : s_axi.wstrb;
    old_pad  = '0;
    new_pad  = '0;
    strb_pad = '0;
    old_pad[DW-1:0]  = regs[w_idx];
    new_pad[DW-1:0]  = wd_sel;
    strb_pad[SW-1:0] = ws_sel;
    merged_pad = strb_merge(old_pad, new_pad, strb_pad);
    merged     = merged_pad[DW-1:0];
  end

  // Write channel next state: capture AW/W independently, commit, then hold B until accepted.
  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wr_pulse_d = 1'b0;
    wr_idx_d   = wr_idx_o;
    case (wr_state_q)
      W_IDLE: begin
        if (commit) begin
          wr_state_d = W_RESP;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = w_in_range ? RESP_OKAY : RESP_SLVERR;
          if (w_in_range) begin
            wr_pulse_d = 1'b1;
            wr_idx_d   = w_idx;
          end
        end else begin
          if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_axi.awaddr;
            awready_d = 1'b0;
          end else if (!aw_held_q) begin
            awready_d = 1'b1;
          end
          if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi.wdata;
            wstrb_d  = s_axi.wstrb;
            wready_d = 1'b0;
          end else if (!w_held_q) begin
            wready_d = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (s_axi.bready) begin
          wr_state_d = W_IDLE;
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write channel state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_pulse_o <= 1'b0;
      wr_idx_o   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wr_pulse_o <= wr_pulse_d;
      wr_idx_o   <= wr_idx_d;
    end
  end

  // Register bank: byte-merged update on an in-range commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (commit && w_in_range) begin
      regs[w_idx] <= merged;
    end
  end

  // Read channel next state: sample the bank on AR (pre-write value on a same-cycle commit).
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    ar_hs      = s_axi.arvalid & arready_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rd_state_d = R_RESP;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rdata_d    = r_in_range ? regs[r_idx] : '0;
          rresp_d    = r_in_range ? RESP_OKAY : RESP_SLVERR;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_RESP: begin
        if (s_axi.rready) begin
          rd_state_d = R_IDLE;
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read channel state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_o[i*DW +: DW] = regs[i];
  end

endmodule

// File: tb/tb_axi_light_reg_slave.sv
// tb/tb_axi_light_reg_slave.sv - randomized self-checking bench for axi_light_reg_slave
module tb_axi_light_reg_slave;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int NREG = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NREG*32-1:0] regs_o;
  logic wr_pulse_o;
  logic [2:0] wr_idx_o;

  if_axi_light #(.DW(32), .AW(32)) axi();

  axi_light_reg_slave #(
    .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .NUM_REGS(NREG),
    .BASE_ADDR(BASE), .RESET_VAL(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .s_axi(axi),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o), .wr_idx_o(wr_idx_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] model [NREG];
  int pulse_q[$];
  int exp_q[$];

  always @(negedge clk) if (wr_pulse_o) pulse_q.push_back(int'(wr_idx_o));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_win(logic [31:0] a);
    return (a >= BASE) && (a < BASE + NREG * 4);
  endfunction

  function automatic int idx_of(logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [NREG*32-1:0] model_flat();
    logic [NREG*32-1:0] r;
    for (int i = 0; i < NREG; i++) r[i*32 +: 32] = model[i];
    return r;
  endfunction

  function automatic void model_write(logic [31:0] a, logic [31:0] d, logic [3:0] s);
    logic [31:0] mask;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
    if (in_win(a)) begin
      model[idx_of(a)] = (model[idx_of(a)] & ~mask) | (d & mask);
      exp_q.push_back(idx_of(a));
    end
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
    int cyc;
    bit aw_done, w_done, aw_hs, w_hs;
    aw_done = 0; w_done = 0; cyc = 0; resp = 2'bxx;
    axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
    while (!(aw_done && w_done) && cyc < 60) begin
      axi.awvalid = !aw_done && (cyc >= aw_dly);
      axi.wvalid  = !w_done && (cyc >= w_dly);
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      cyc++;
    end
    axi.awvalid = 0; axi.wvalid = 0;
    n_cmp++;
    if (!(aw_done && w_done)) begin
      n_bad++; $display("FAIL write_accept_timeout addr=%h got aw=%0b w=%0b want both 1", a, aw_done, w_done);
      return;
    end
    repeat (b_dly) tick();
    axi.bready = 1; cyc = 0;
    while (!axi.bvalid && cyc < 60) begin tick(); cyc++; end
    n_cmp++;
    if (!axi.bvalid) begin n_bad++; $display("FAIL bvalid_timeout addr=%h got 0 want 1", a); end
    resp = axi.bresp;
    tick();
    axi.bready = 0;
  endtask

  task automatic do_read(input logic [31:0] a, input int r_dly, output logic [31:0] d, output logic [1:0] resp);
    int cyc;
    bit done;
    d = 'x; resp = 2'bxx; cyc = 0; done = 0;
    axi.araddr = a; axi.arvalid = 1;
    while (!done && cyc < 60) begin done = axi.arready; tick(); cyc++; end
    axi.arvalid = 0;
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL arready_timeout addr=%h got 0 want 1", a); return; end
    repeat (r_dly) tick();
    axi.rready = 1; cyc = 0;
    while (!axi.rvalid && cyc < 60) begin tick(); cyc++; end
    n_cmp++;
    if (!axi.rvalid) begin n_bad++; $display("FAIL rvalid_timeout addr=%h got 0 want 1", a); end
    d = axi.rdata; resp = axi.rresp;
    tick();
    axi.rready = 0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_cmp++; if ({axi.awready, axi.wready, axi.arready} !== 3'b000) begin n_bad++; $display("FAIL reset_readies got %b want 000", {axi.awready, axi.wready, axi.arready}); end
    n_cmp++; if ({axi.bvalid, axi.rvalid, axi.bresp, axi.rresp} !== 6'b0) begin n_bad++; $display("FAIL reset_resp got %b want 0", {axi.bvalid, axi.rvalid, axi.bresp, axi.rresp}); end
    n_cmp++; if (axi.rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", axi.rdata); end
    n_cmp++; if (regs_o !== model_flat()) begin n_bad++; $display("FAIL reset_regs got %h want %h", regs_o, model_flat()); end
    n_cmp++; if ({wr_pulse_o, wr_idx_o} !== 4'b0) begin n_bad++; $display("FAIL reset_pulse got %b want 0", {wr_pulse_o, wr_idx_o}); end
    reset = 0;
    n_cmp++; if ({axi.awready, axi.wready, axi.arready} !== 3'b000) begin n_bad++; $display("FAIL ready_before_edge got %b want 000", {axi.awready, axi.wready, axi.arready}); end
    tick();
    n_cmp++; if ({axi.awready, axi.wready, axi.arready} !== 3'b111) begin n_bad++; $display("FAIL ready_after_reset got %b want 111", {axi.awready, axi.wready, axi.arready}); end
  endtask

  task automatic test_write_same_cycle();
    pulse_q.delete();
    axi.awaddr = BASE + 32'h4; axi.wdata = 32'hDEADBEEF; axi.wstrb = 4'hF;
    axi.awvalid = 1; axi.wvalid = 1;
    tick();
    axi.awvalid = 0; axi.wvalid = 0;
    model[1] = 32'hDEADBEEF;
    n_cmp++; if ({axi.bvalid, axi.bresp} !== 3'b100) begin n_bad++; $display("FAIL samecyc_b got %b want 100", {axi.bvalid, axi.bresp}); end
    n_cmp++; if (regs_o[1*32 +: 32] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL samecyc_reg1 got %h want deadbeef", regs_o[1*32 +: 32]); end
    n_cmp++; if ({wr_pulse_o, wr_idx_o} !== 4'b1001) begin n_bad++; $display("FAIL samecyc_pulse got %b want 1001", {wr_pulse_o, wr_idx_o}); end
    n_cmp++; if ({axi.awready, axi.wready} !== 2'b00) begin n_bad++; $display("FAIL samecyc_ready_in_resp got %b want 00", {axi.awready, axi.wready}); end
    axi.bready = 1;
    tick();
    axi.bready = 0;
    n_cmp++; if ({axi.bvalid, wr_pulse_o, axi.awready, axi.wready} !== 4'b0011) begin n_bad++; $display("FAIL samecyc_after_b got %b want 0011", {axi.bvalid, wr_pulse_o, axi.awready, axi.wready}); end
    n_cmp++; if (pulse_q.size() != 1 || pulse_q[0] != 1) begin n_bad++; $display("FAIL samecyc_pulse_count got %0d want 1", pulse_q.size()); end
    pulse_q.delete();
  endtask

  task automatic test_w_before_aw();
    axi.awaddr = BASE + 32'h8; axi.wdata = 32'h11223344; axi.wstrb = 4'b0101;
    axi.wvalid = 1;
    tick();
    axi.wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({axi.wready, axi.awready, axi.bvalid} !== 3'b010) begin n_bad++; $display("FAIL wfirst_wait%0d got %b want 010", i, {axi.wready, axi.awready, axi.bvalid}); end
      if (i < 2) tick();
    end
    axi.awvalid = 1;
    tick();
    axi.awvalid = 0;
    model_write(BASE + 32'h8, 32'h11223344, 4'b0101);
    n_cmp++; if ({axi.bvalid, axi.bresp} !== 3'b100) begin n_bad++; $display("FAIL wfirst_b got %b want 100", {axi.bvalid, axi.bresp}); end
    n_cmp++; if (regs_o[2*32 +: 32] !== model[2]) begin n_bad++; $display("FAIL wfirst_reg2 got %h want %h", regs_o[2*32 +: 32], model[2]); end
    axi.bready = 1; tick(); axi.bready = 0;
    exp_q.delete(); pulse_q.delete();
  endtask

  task automatic test_read_backpressure();
    logic [1:0] resp;
    logic [31:0] v;
    v = $urandom;
    do_write(BASE + 32'h1C, v, 4'hF, 0, 0, 0, resp);
    model_write(BASE + 32'h1C, v, 4'hF);
    axi.araddr = BASE + 32'h1C; axi.arvalid = 1; axi.rready = 0;
    tick();
    axi.arvalid = 0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({axi.rvalid, axi.arready, axi.rresp, axi.rdata} !== {2'b10, 2'b00, model[7]}) begin n_bad++; $display("FAIL rd_hold%0d got %b/%h want 1000/%h", i, {axi.rvalid, axi.arready, axi.rresp}, axi.rdata, model[7]); end
      if (i < 3) tick();
    end
    axi.rready = 1; tick(); axi.rready = 0;
    n_cmp++; if ({axi.rvalid, axi.arready} !== 2'b01) begin n_bad++; $display("FAIL rd_release got %b want 01", {axi.rvalid, axi.arready}); end
    exp_q.delete(); pulse_q.delete();
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp;
    logic [31:0] d;
    logic [31:0] addrs [2];
    addrs[0] = BASE + NREG * 4; addrs[1] = BASE - 4;
    pulse_q.delete();
    foreach (addrs[k]) begin
      do_write(addrs[k], $urandom, 4'hF, 0, 0, 0, resp);
      n_cmp++; if (resp !== 2'b10) begin n_bad++; $display("FAIL oor_bresp%0d got %b want 10", k, resp); end
      do_read(addrs[k], 0, d, resp);
      n_cmp++; if ({resp, d} !== {2'b10, 32'h0}) begin n_bad++; $display("FAIL oor_read%0d got %b/%h want 10/0", k, resp, d); end
    end
    n_cmp++; if (regs_o !== model_flat()) begin n_bad++; $display("FAIL oor_regs got %h want %h", regs_o, model_flat()); end
    n_cmp++; if (pulse_q.size() != 0) begin n_bad++; $display("FAIL oor_pulse got %0d pulses want 0", pulse_q.size()); end
  endtask

  task automatic test_conflict();
    logic [1:0] resp;
    logic [31:0] d;
    do_write(BASE + 32'hC, 32'hA5A5A5A5, 4'hF, 0, 0, 0, resp);
    model_write(BASE + 32'hC, 32'hA5A5A5A5, 4'hF);
    axi.awaddr = BASE + 32'hC; axi.wdata = 32'h5A5A5A5A; axi.wstrb = 4'hF;
    axi.araddr = BASE + 32'hC;
    axi.awvalid = 1; axi.wvalid = 1; axi.arvalid = 1;
    tick();
    axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0;
    n_cmp++; if ({axi.rvalid, axi.bvalid, axi.rdata} !== {2'b11, 32'hA5A5A5A5}) begin n_bad++; $display("FAIL conflict_read got %b/%h want 11/a5a5a5a5", {axi.rvalid, axi.bvalid}, axi.rdata); end
    axi.bready = 1; axi.rready = 1; tick(); axi.bready = 0; axi.rready = 0;
    model_write(BASE + 32'hC, 32'h5A5A5A5A, 4'hF);
    do_read(BASE + 32'hC, 0, d, resp);
    n_cmp++; if ({resp, d} !== {2'b00, 32'h5A5A5A5A}) begin n_bad++; $display("FAIL conflict_reread got %b/%h want 00/5a5a5a5a", resp, d); end
    exp_q.delete(); pulse_q.delete();
  endtask

  task automatic test_random();
    logic [1:0] resp;
    logic [31:0] a, d, exp_d;
    logic [3:0] s;
    int kind;
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) a = BASE + NREG * 4 + 4 * $urandom_range(0, 7);
      else if (kind == 1) a = BASE - 4 * $urandom_range(1, 4);
      else a = BASE + 4 * $urandom_range(0, NREG - 1) + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom_range(0, 15));
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp);
        model_write(a, d, s);
        n_cmp++; if (resp !== (in_win(a) ? 2'b00 : 2'b10)) begin n_bad++; $display("FAIL rnd_bresp it=%0d addr=%h got %b", it, a, resp); end
        n_cmp++;
        if (pulse_q.size() != exp_q.size() || (exp_q.size() == 1 && pulse_q[0] != exp_q[0])) begin
          n_bad++; $display("FAIL rnd_pulse it=%0d got %0d pulses want %0d", it, pulse_q.size(), exp_q.size());
        end
        pulse_q.delete(); exp_q.delete();
      end else begin
        exp_d = in_win(a) ? model[idx_of(a)] : 32'h0;
        do_read(a, $urandom_range(0, 3), d, resp);
        n_cmp++; if ({resp, d} !== {(in_win(a) ? 2'b00 : 2'b10), exp_d}) begin n_bad++; $display("FAIL rnd_read it=%0d addr=%h got %b/%h want %h", it, a, resp, d, exp_d); end
      end
      n_cmp++; if (regs_o !== model_flat()) begin n_bad++; $display("FAIL rnd_regs it=%0d got %h want %h", it, regs_o, model_flat()); end
    end
  endtask

  task automatic test_reset_mid();
    axi.awaddr = BASE + 32'h10; axi.wdata = $urandom; axi.wstrb = 4'hF;
    axi.araddr = BASE + 32'h10;
    axi.awvalid = 1; axi.wvalid = 1; axi.arvalid = 1;
    tick();
    axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0;
    n_cmp++; if ({axi.bvalid, axi.rvalid} !== 2'b11) begin n_bad++; $display("FAIL midrst_pending got %b want 11", {axi.bvalid, axi.rvalid}); end
    reset = 1;
    tick();
    for (int i = 0; i < NREG; i++) model[i] = 32'h0;
    n_cmp++; if ({axi.bvalid, axi.rvalid, axi.awready, axi.wready, axi.arready} !== 5'b0) begin n_bad++; $display("FAIL midrst_clear got %b want 00000", {axi.bvalid, axi.rvalid, axi.awready, axi.wready, axi.arready}); end
    n_cmp++; if (regs_o !== model_flat()) begin n_bad++; $display("FAIL midrst_regs got %h want %h", regs_o, model_flat()); end
    reset = 0;
    tick();
    n_cmp++; if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid} !== 5'b11100) begin n_bad++; $display("FAIL midrst_resume got %b want 11100", {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid}); end
    tick();
    n_cmp++; if ({axi.bvalid, axi.rvalid} !== 2'b00) begin n_bad++; $display("FAIL midrst_no_resp got %b want 00", {axi.bvalid, axi.rvalid}); end
  endtask

  initial begin
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 0; axi.bready = 0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 0; axi.rready = 0;
    for (int i = 0; i < NREG; i++) model[i] = 32'h0;
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_read_backpressure();
    test_out_of_range();
    test_conflict();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
